// File: rtl/menu_app_sequencer.sv
`default_nettype none
// ============================================================================
// menu_app_sequencer : menu cursor, app selection, blanked screen changes,
//                      idle auto-return and OLED pixel-source arbitration.
// Revision: 1.0
// ============================================================================
module menu_app_sequencer #(
  parameter int BLANK_FRAMES = 2,
  parameter int IDLE_LIMIT   = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        tick,
  input  logic        frame_begin,
  input  logic [15:0] menu_oled_data,
  input  logic [63:0] app_oled_data,
  output logic [3:0]  state,
  output logic [1:0]  menu_sel,
  output logic        blanking,
  output logic [15:0] oled_data
);

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_BLANK = 2'd1,
    S_APP   = 2'd2
  } fsm_t;

  localparam logic [3:0] c_BLANK_LAST = 4'(BLANK_FRAMES - 1);
  localparam logic [7:0] c_IDLE_LAST  = 8'(IDLE_LIMIT - 1);

  fsm_t        fsm_q, fsm_d;
  logic [3:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  target_q, target_d;
  logic [7:0]  idle_q, idle_d;
  logic [3:0]  frame_q, frame_d;
  logic        blank_q, blank_d;
  logic [15:0] oled_q, oled_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= S_MENU;
      state_q  <= 4'd0;
      sel_q    <= 2'd0;
      target_q <= 4'd0;
      idle_q   <= 8'd0;
      frame_q  <= 4'd0;
      blank_q  <= 1'b0;
      oled_q   <= 16'h0000;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      idle_q   <= idle_d;
      frame_q  <= frame_d;
      blank_q  <= blank_d;
      oled_q   <= oled_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    idle_d   = idle_q;
    frame_d  = frame_q;
    blank_d  = blank_q;

    unique case (fsm_q)
      S_MENU: begin
        if (btnC) begin
          target_d = {2'b00, sel_q} + 4'd1;
          frame_d  = 4'd0;
          blank_d  = 1'b1;
          fsm_d    = S_BLANK;
        end else if (btnU && !btnD && sel_q != 2'd0) begin
          sel_d = sel_q - 2'd1;
        end else if (btnD && !btnU && sel_q != 2'd3) begin
          sel_d = sel_q + 2'd1;
        end
      end
      S_APP: begin
        if (btnL) begin
          target_d = 4'd0;
          frame_d  = 4'd0;
          blank_d  = 1'b1;
          fsm_d    = S_BLANK;
        end else if (btnU || btnD || btnC) begin
          idle_d = 8'd0;
        end else if (tick) begin
          if (idle_q == c_IDLE_LAST) begin
            target_d = 4'd0;
            frame_d  = 4'd0;
            blank_d  = 1'b1;
            fsm_d    = S_BLANK;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
      end
      S_BLANK: begin
        if (frame_begin) begin
          if (frame_q == c_BLANK_LAST) begin
            state_d = target_q;
            blank_d = 1'b0;
            idle_d  = 8'd0;
            fsm_d   = (target_q == 4'd0) ? S_MENU : S_APP;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end
      end
      default: fsm_d = S_MENU;
    endcase
  end

  // Source follows next-state values so black and the new screen land on the
  // same edge as the corresponding FSM transition.
  always_comb begin
    oled_d = 16'h0000;
    if (!blank_d) begin
      case (state_d)
        4'd0:    oled_d = menu_oled_data;
        4'd1:    oled_d = app_oled_data[15:0];
        4'd2:    oled_d = app_oled_data[31:16];
        4'd3:    oled_d = app_oled_data[47:32];
        4'd4:    oled_d = app_oled_data[63:48];
        default: oled_d = 16'h0000;
      endcase
    end
  end

  assign state     = state_q;
  assign menu_sel  = sel_q;
  assign blanking  = blank_q;
  assign oled_data = oled_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_app_sequencer.sv
`default_nettype none
// ============================================================================
// tb_menu_app_sequencer : directed self-checking bench for menu_app_sequencer.
// Revision: 1.0
// ============================================================================
module tb_menu_app_sequencer;

  localparam logic [15:0] c_MENU_PIX = 16'hA5A5;
  localparam logic [63:0] c_APP_PIX  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic        clk = 1'b0;
  logic        reset, btnU, btnD, btnC, btnL, tick, frame_begin;
  logic [15:0] menu_oled_data;
  logic [63:0] app_oled_data;
  logic [3:0]  state;
  logic [1:0]  menu_sel;
  logic        blanking;
  logic [15:0] oled_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  menu_app_sequencer #(
    .BLANK_FRAMES(2),
    .IDLE_LIMIT  (3)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btnU          (btnU),
    .btnD          (btnD),
    .btnC          (btnC),
    .btnL          (btnL),
    .tick          (tick),
    .frame_begin   (frame_begin),
    .menu_oled_data(menu_oled_data),
    .app_oled_data (app_oled_data),
    .state         (state),
    .menu_sel      (menu_sel),
    .blanking      (blanking),
    .oled_data     (oled_data)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Hold the given inputs for one rising edge, then release; sample 1ns after.
  task automatic pulse(input logic r, input logic u, input logic d, input logic c,
                       input logic l, input logic t, input logic f);
    reset = r; btnU = u; btnD = d; btnC = c; btnL = l; tick = t; frame_begin = f;
    @(posedge clk);
    #1;
    reset = 1'b0; btnU = 1'b0; btnD = 1'b0; btnC = 1'b0; btnL = 1'b0;
    tick = 1'b0; frame_begin = 1'b0;
  endtask

  task automatic idle();
    pulse(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic frames2();
    pulse(0, 0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    menu_oled_data = c_MENU_PIX;
    app_oled_data  = c_APP_PIX;
    reset = 1'b1; btnU = 1'b0; btnD = 1'b0; btnC = 1'b0; btnL = 1'b0;
    tick = 1'b0; frame_begin = 1'b0;
    @(posedge clk); #1;
    pulse(1, 0, 0, 0, 0, 0, 0);
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_sel", 16'(menu_sel), 16'h0);
    chk("rst_blank", 16'(blanking), 16'h0);
    chk("rst_oled", oled_data, 16'h0000);

    // Cursor saturation
    pulse(0, 0, 1, 0, 0, 0, 0); chk("d1_sel", 16'(menu_sel), 16'd1);
    chk("menu_oled", oled_data, c_MENU_PIX);
    pulse(0, 0, 1, 0, 0, 0, 0); chk("d2_sel", 16'(menu_sel), 16'd2);
    pulse(0, 0, 1, 0, 0, 0, 0); chk("d3_sel", 16'(menu_sel), 16'd3);
    pulse(0, 0, 1, 0, 0, 0, 0); chk("d4_sel", 16'(menu_sel), 16'd3);
    pulse(0, 0, 1, 0, 0, 0, 0); chk("d5_sel", 16'(menu_sel), 16'd3);
    pulse(0, 1, 1, 0, 0, 0, 0); chk("ud_sel", 16'(menu_sel), 16'd3);
    chk("menu_state", 16'(state), 16'h0);
    pulse(0, 1, 0, 0, 0, 0, 0); chk("u_sel", 16'(menu_sel), 16'd2);
    pulse(0, 0, 0, 0, 1, 0, 0); chk("l_ign", 16'(blanking), 16'd0);

    // Select app at cursor 2 -> state 0011
    pulse(0, 0, 0, 1, 0, 0, 0);
    chk("c_blank", 16'(blanking), 16'd1);
    chk("c_oled", oled_data, 16'h0000);
    chk("c_state", 16'(state), 16'h0);
    pulse(0, 0, 0, 0, 0, 0, 1);
    chk("f1_blank", 16'(blanking), 16'd1);
    chk("f1_state", 16'(state), 16'h0);
    pulse(0, 0, 0, 0, 0, 0, 1);
    chk("f2_state", 16'(state), 16'h3);
    chk("f2_blank", 16'(blanking), 16'd0);
    idle();
    chk("app3_oled", oled_data, 16'h3333);

    // Back to menu, move to 0, enter app 0001
    pulse(0, 0, 0, 0, 1, 0, 0); chk("back_blank", 16'(blanking), 16'd1);
    frames2();
    chk("back_state", 16'(state), 16'h0);
    chk("back_sel", 16'(menu_sel), 16'd2);
    pulse(0, 1, 0, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0, 0);
    frames2();
    chk("app1_state", 16'(state), 16'h1);
    chk("app1_oled", oled_data, 16'h1111);

    // Idle timeout with a button clearing the count
    pulse(0, 0, 0, 0, 0, 1, 0);
    pulse(0, 0, 0, 0, 0, 1, 0);
    chk("t2_blank", 16'(blanking), 16'd0);
    pulse(0, 0, 0, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1, 0);
    chk("t3_blank", 16'(blanking), 16'd0);
    chk("t3_state", 16'(state), 16'h1);
    pulse(0, 0, 0, 0, 0, 1, 0);
    chk("t4_blank", 16'(blanking), 16'd0);
    pulse(0, 0, 0, 0, 0, 1, 0);
    chk("t5_blank", 16'(blanking), 16'd1);
    chk("t5_state", 16'(state), 16'h1);
    chk("t5_oled", oled_data, 16'h0000);
    frames2();
    chk("to_state", 16'(state), 16'h0);
    chk("to_sel", 16'(menu_sel), 16'd0);

    // App 0010: button+tick clears, btnL+tick blanks once, blank ignores buttons
    pulse(0, 0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0, 0);
    frames2();
    chk("app2_state", 16'(state), 16'h2);
    pulse(0, 0, 0, 0, 0, 1, 0);
    pulse(0, 0, 0, 0, 0, 1, 0);
    pulse(0, 1, 0, 0, 0, 1, 0);
    chk("bt_blank", 16'(blanking), 16'd0);
    pulse(0, 0, 0, 0, 0, 1, 0);
    chk("bt2_blank", 16'(blanking), 16'd0);
    pulse(0, 0, 0, 0, 1, 1, 0);
    chk("lt_blank", 16'(blanking), 16'd1);
    chk("lt_state", 16'(state), 16'h2);
    pulse(0, 0, 0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0, 0);
    frames2();
    chk("lt_state2", 16'(state), 16'h0);
    chk("lt_sel", 16'(menu_sel), 16'd1);
    chk("lt_oled", oled_data, c_MENU_PIX);

    // Reset mid-blank
    pulse(0, 0, 0, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 0, 1);
    pulse(1, 0, 0, 0, 0, 0, 0);
    chk("rb_state", 16'(state), 16'h0);
    chk("rb_sel", 16'(menu_sel), 16'd0);
    chk("rb_blank", 16'(blanking), 16'd0);
    chk("rb_oled", oled_data, 16'h0000);
    idle();
    chk("rb_oled2", oled_data, c_MENU_PIX);

    // Reset mid-app
    pulse(0, 0, 0, 1, 0, 0, 0);
    frames2();
    chk("ra_pre", 16'(state), 16'h1);
    pulse(1, 0, 0, 0, 0, 0, 0);
    chk("ra_state", 16'(state), 16'h0);
    chk("ra_blank", 16'(blanking), 16'd0);
    chk("ra_oled", oled_data, 16'h0000);
    idle();
    chk("ra_oled2", oled_data, c_MENU_PIX);

    // btnC beats btnU
    pulse(0, 0, 1, 0, 0, 0, 0);
    pulse(0, 1, 0, 1, 0, 0, 0);
    chk("cu_sel", 16'(menu_sel), 16'd1);
    chk("cu_blank", 16'(blanking), 16'd1);
    frames2();
    chk("cu_state", 16'(state), 16'h2);
    chk("cu_oled", oled_data, 16'h2222);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/menu_app_sequencer.md
Name: menu_app_sequencer

Overview:
- Top-level screen/state controller for the Basys3 + 96x64 OLED design.
- Owns the menu cursor and the active-application state. Sequences menu -> app -> menu transitions with a blanking interval.
- Arbitrates the single OLED pixel stream between the menu renderer and four application renderers.
- Returns to the menu automatically after an idle timeout.

Parameters:
- BLANK_FRAMES, 2, number of frame_begin pulses the OLED is forced black on every screen change (1..15).
- IDLE_LIMIT, 30, tick pulses with no button activity in an app before auto-return to menu (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btnU  in  1  single-cycle debounced pulse: cursor up
- btnD  in  1  single-cycle debounced pulse: cursor down
- btnC  in  1  single-cycle debounced pulse: select
- btnL  in  1  single-cycle debounced pulse: back
- tick  in  1  single-cycle timebase pulse (1 Hz in the top level)
- frame_begin  in  1  single-cycle pulse from the OLED driver at frame start
- menu_oled_data  in  16  RGB565 pixel from the menu renderer
- app_oled_data  in  64  four RGB565 pixels; app k occupies bits [16k+15:16k]
- state  out  4  0000 = menu, 0001..0100 = app 0..3
- menu_sel  out  2  current cursor position
- blanking  out  1  high while the screen is forced black
- oled_data  out  16  pixel to the OLED driver, registered

Behaviour:
- Internal FSM: S_MENU, S_BLANK, S_APP. Reset state is S_MENU.
- Reset values: state=0000, menu_sel=00, blanking=0, oled_data=16'h0000. Internal counters are cleared and the pending target is 0000.
- Reset has priority over every other input in the same cycle. A reset mid-blank or mid-app goes straight to S_MENU.

S_MENU:
- btnU with menu_sel>0: decrement menu_sel. btnD with menu_sel<3: increment menu_sel.
- btnU at 0 and btnD at 3 are ignored (saturating, no wrap).
- btnU and btnD in the same cycle: no move.
- btnC: load target = menu_sel+1, then go to S_BLANK. btnC beats btnU/btnD/btnL in the same cycle, and menu_sel does not move that cycle.
- btnL: ignored.

S_APP:
- btnL: load target = 0000, then go to S_BLANK. btnL beats tick in the same cycle.
- btnU/btnD/btnC: ignored by this block (the apps consume them), but they clear the idle counter.
- Idle counter: 8-bit. Cleared on any button pulse and on entry to S_APP. Incremented on tick. When a tick arrives with counter == IDLE_LIMIT-1, load target = 0000 and go to S_BLANK.
- A button and a tick in the same cycle: the counter clears and no timeout occurs.
- menu_sel holds its value through the app, so the menu returns with the last app highlighted.

S_BLANK:
- blanking=1. The state output still shows the old screen.
- Frame counter is cleared on entry and increments on each frame_begin.
- When a frame_begin arrives with count == BLANK_FRAMES-1: on the next edge, state <= target, blanking <= 0, and the FSM goes to S_MENU if target==0000, otherwise to S_APP.
- All buttons and ticks are ignored during blank.

Pixel arbitration (registered, 1-cycle latency):
- oled_data <= 0 if blanking (next-state value).
- Otherwise menu_oled_data if the next state is 0000.
- Otherwise the app_oled_data slice selected by the next state.
- Consequence: black appears on the same edge the FSM enters S_BLANK, and the new source appears on the same edge state changes.

Width rules:
- target = {2'b00, menu_sel} + 1, computed in 4 bits.
- Values 0101..1111 on state are never produced.

Test Plan:
- Reset, then btnD x5 pulses -> menu_sel goes 1,2,3,3,3; then btnU+btnD in the same cycle -> menu_sel stays 3; state=0000 throughout.
- menu_sel=2, btnC, then 2 frame_begin pulses -> blanking=1 and oled_data=0 from the edge after btnC. On the edge after the second frame_begin: state=0011, blanking=0, and oled_data equals app_oled_data[47:32] one cycle later.
- In app 0001 with IDLE_LIMIT=3: 3 ticks, with btnC pulsed between tick 2 and tick 3 -> no return. A further 3 ticks with no buttons -> enters S_BLANK; state=0000 after 2 frames; menu_sel is preserved.
- In app, btnL and tick in the same cycle -> single transition to S_BLANK with target 0000. Extra btnC/btnD pulses during blank are ignored: state=0000 and menu_sel is unchanged afterwards.
- Reset asserted during S_BLANK (1 frame in) and during S_APP -> next edge: state=0000, menu_sel=0, blanking=0, oled_data=0. The following cycle shows menu_oled_data.
- In menu, btnC and btnU in the same cycle with menu_sel=1 -> target 0010, menu_sel stays 1.
